microcode_sequencer: RTL and testbench

//  Parametrised successor to the fixed 5-phase control unit of the 8-bit SAP machine.
//  - Steps a microinstruction counter t through up to MAX_STEP phases per instruction.
//  - Decodes (opcode, t, flags) into the CW-bit control word that drives every datapath block.
//  - New behaviour: halt state, run/single-step mode, per-instruction done pulse, optional early end.
//  - Sits between the instruction register / flags register and all register, ALU, RAM and PC enables.

---
 rtl/sap_ctl_pkg.sv | 79 +++++++
 rtl/ustep_counter.sv | 42 ++++
 rtl/microcode_sequencer.sv | 140 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_ctl_pkg.sv
// ---------------------------------------------------------------------------
// sap_ctl_pkg
// Shared definitions for the SAP microcode sequencer:
//   - ctl_bit_e   : bit positions inside the control word (bit index = value)
//   - CW_W        : control-word width
//   - OP_*        : opcode constants (high nibble of the instruction register)
//   - seq_state_e : sequencer FSM states
//   - ucode()     : microcode ROM, (opcode, step, cf, zf) -> control word
// ---------------------------------------------------------------------------
package sap_ctl_pkg;

  localparam int CW_W = 16;

  typedef enum logic [3:0] {
    HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI
  } ctl_bit_e;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_LDA = 8'd1;
  localparam logic [7:0] OP_ADD = 8'd2;
  localparam logic [7:0] OP_SUB = 8'd3;
  localparam logic [7:0] OP_STA = 8'd4;
  localparam logic [7:0] OP_LDI = 8'd5;
  localparam logic [7:0] OP_JMP = 8'd6;
  localparam logic [7:0] OP_JC  = 8'd7;
  localparam logic [7:0] OP_JZ  = 8'd8;
  localparam logic [7:0] OP_OUT = 8'd14;
  localparam logic [7:0] OP_HLT = 8'd15;

  // Opcode and step are passed zero-extended to 8 bits so the ROM does not
  // depend on the sequencer's O/T parameters. Steps with no entry are zero.
  function automatic logic [CW_W-1:0] ucode(input logic [7:0] opcode,
                                            input logic [7:0] step,
                                            input logic       cf,
                                            input logic       zf);
    logic [CW_W-1:0] cw;
    cw = '0;
    case (step)
      8'd0: begin cw[CO] = 1'b1; cw[MI] = 1'b1; end
      8'd1: begin cw[RO] = 1'b1; cw[II] = 1'b1; cw[CE] = 1'b1; end
      8'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin cw[IO] = 1'b1; cw[MI] = 1'b1; end
          OP_LDI: begin cw[IO] = 1'b1; cw[AI] = 1'b1; end
          OP_JMP: begin cw[IO] = 1'b1; cw[J] = 1'b1; end
          OP_JC:  begin cw[IO] = cf;   cw[J] = cf;   end
          OP_JZ:  begin cw[IO] = zf;   cw[J] = zf;   end
          OP_OUT: begin cw[AO] = 1'b1; cw[OI] = 1'b1; end
          OP_HLT: cw[HLT] = 1'b1;
          default: cw = '0;
        endcase
      end
      8'd3: begin
        case (opcode)
          OP_LDA: begin cw[RO] = 1'b1; cw[AI] = 1'b1; end
          OP_ADD, OP_SUB: begin cw[RO] = 1'b1; cw[BI] = 1'b1; end
          OP_STA: begin cw[AO] = 1'b1; cw[RI] = 1'b1; end
          default: cw = '0;
        endcase
      end
      8'd4: begin
        case (opcode)
          OP_ADD: begin cw[EO] = 1'b1; cw[AI] = 1'b1; cw[FI] = 1'b1; end
          OP_SUB: begin cw[EO] = 1'b1; cw[AI] = 1'b1; cw[SU] = 1'b1; cw[FI] = 1'b1; end
          default: cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/ustep_counter.sv
// ---------------------------------------------------------------------------
// ustep_counter
// Modulo-MAX_STEP microinstruction step counter.
// Ports:
//   clk    in  : rising-edge clock
//   clr_   in  : asynchronous active-low reset (t -> 0)
//   clear  in  : synchronous clear to 0 (wins over advance)
//   hold   in  : 1 = keep the current value
//   t      out : current step, always in 0..MAX_STEP-1
// ---------------------------------------------------------------------------
module ustep_counter #(
  parameter int T        = 3,
  parameter int MAX_STEP = 5
) (
  input  logic         clk,
  input  logic         clr_,
  input  logic         clear,
  input  logic         hold,
  output logic [T-1:0] t
);

  logic [T-1:0] t_q;
  logic [T-1:0] t_d;

  // Wrap at MAX_STEP-1 rather than relying on 2**T rollover.
  always_comb begin
    t_d = t_q;
    if (clear) begin
      t_d = '0;
    end else if (!hold) begin
      t_d = (t_q == T'(MAX_STEP - 1)) ? '0 : t_q + T'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) t_q <= '0;
    else       t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
// Steps the microinstruction counter and decodes (opcode, t, flags) into the
// control word of the SAP datapath. Supports free-run, single-step and halt.
//
// Ports:
//   clk        in  : rising-edge clock
//   clr_       in  : asynchronous active-low reset
//   sw_run     in  : 1 = free run, 0 = single-step
//   step       in  : single-step request; one step per rising edge seen in WAIT
//   ir [O]     in  : opcode field of the instruction register
//   cf, zf     in  : latched carry / zero flags
//   ctl [CW]   out : control word, bit order from sap_ctl_pkg::ctl_bit_e
//   t [T]      out : current step number
//   halted     out : 1 while in HALT
//   instr_done out : 1 during the final step of each instruction
//   dbg_state  out : FSM state (sap_ctl_pkg::seq_state_e encoding)
//
// Build option: define USTEP_EARLY_END_EN to end an instruction as soon as
// the next step's control word would be all-zero (from t>=2 onward).
//
// Step request semantics: a step is taken when WAIT sees step high while it
// was low the previous cycle; a held request yields one step only and must
// drop before another can be seen. step during RUN or HALT is ignored.
// ---------------------------------------------------------------------------
module microcode_sequencer
  import sap_ctl_pkg::*;
#(
  parameter int O        = 4,
  parameter int T        = 3,
  parameter int MAX_STEP = 5,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          clr_,
  input  logic          sw_run,
  input  logic          step,
  input  logic [O-1:0]  ir,
  input  logic          cf,
  input  logic          zf,
  output logic [CW-1:0] ctl,
  output logic [T-1:0]  t,
  output logic          halted,
  output logic          instr_done,
  output logic [1:0]    dbg_state
);

  if ((2 ** T) < MAX_STEP) begin : g_chk_t
    $error("microcode_sequencer: 2**T must be >= MAX_STEP");
  end
  if (MAX_STEP < 3) begin : g_chk_max
    $error("microcode_sequencer: MAX_STEP must be >= 3");
  end
  if (CW != CW_W) begin : g_chk_cw
    $error("microcode_sequencer: CW must equal sap_ctl_pkg::CW_W");
  end
  if (O > 8 || T > 8) begin : g_chk_w
    $error("microcode_sequencer: O and T must not exceed 8");
  end

  seq_state_e   state_q, state_d;
  logic         step_prev_q, step_prev_d;
  logic         cnt_clear, cnt_hold;
  logic         early_end;
  logic         last_step;
  logic [7:0]   opc;
  logic [CW_W-1:0] cw_now;

  assign opc    = 8'(ir);
  assign cw_now = ucode(opc, 8'(t), cf, zf);

`ifdef USTEP_EARLY_END_EN
  logic [CW_W-1:0] cw_next;
  assign cw_next   = ucode(opc, 8'(t) + 8'd1, cf, zf);
  assign early_end = (t >= T'(2)) && (cw_next == '0);
`else
  assign early_end = 1'b0;
`endif

  assign last_step = (t == T'(MAX_STEP - 1)) || early_end;

  ustep_counter #(
    .T        (T),
    .MAX_STEP (MAX_STEP)
  ) u_cnt (
    .clk   (clk),
    .clr_  (clr_),
    .clear (cnt_clear),
    .hold  (cnt_hold),
    .t     (t)
  );

  always_comb begin
    state_d     = state_q;
    step_prev_d = step;
    ctl         = '0;
    halted      = 1'b0;
    instr_done  = 1'b0;
    cnt_clear   = 1'b0;
    cnt_hold    = 1'b1;
    unique case (state_q)
      WAIT: begin
        if (sw_run || (step && !step_prev_q)) state_d = RUN;
      end
      RUN: begin
        ctl = cw_now;
        if (cw_now[HLT]) begin
          // t stays on the HLT step; only clr_ leaves HALT.
          state_d = HALT;
        end else begin
          cnt_hold = 1'b0;
          if (last_step) begin
            cnt_clear  = 1'b1;
            instr_done = 1'b1;
          end
          // Each RUN cycle is one complete step, so dropping sw_run here
          // never leaves a partial step behind.
          if (!sw_run) state_d = WAIT;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state_q     <= WAIT;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microcode_sequencer
// Table-driven check of the SAP microcode sequencer plus hand-written
// sequences for halt, single-step, mid-instruction reset, run->step switch
// and a MAX_STEP=6 wrap instance.
// ---------------------------------------------------------------------------
module tb_microcode_sequencer;

  // Control-word bit masks (HLT is bit 0 ... FI is bit 15)
  localparam logic [15:0] B_HLT = 16'h0001, B_MI = 16'h0002, B_RI = 16'h0004;
  localparam logic [15:0] B_RO  = 16'h0008, B_IO = 16'h0010, B_II = 16'h0020;
  localparam logic [15:0] B_AI  = 16'h0040, B_AO = 16'h0080, B_EO = 16'h0100;
  localparam logic [15:0] B_SU  = 16'h0200, B_BI = 16'h0400, B_OI = 16'h0800;
  localparam logic [15:0] B_CE  = 16'h1000, B_CO = 16'h2000, B_J  = 16'h4000;
  localparam logic [15:0] B_FI  = 16'h8000;

  localparam logic [3:0] I_NOP = 4'd0, I_LDA = 4'd1, I_ADD = 4'd2, I_SUB = 4'd3;
  localparam logic [3:0] I_STA = 4'd4, I_LDI = 4'd5, I_JMP = 4'd6, I_JC  = 4'd7;
  localparam logic [3:0] I_JZ  = 4'd8, I_OUT = 4'd14, I_HLT = 4'd15;

  localparam logic [1:0] S_WAIT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;

`ifdef USTEP_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_, sw_run, step, cf, zf;
  logic [3:0]  ir;
  logic [15:0] ctl;
  logic [2:0]  t;
  logic        halted, instr_done;
  logic [1:0]  dbg_state;

  microcode_sequencer #(.O(4), .T(3), .MAX_STEP(5), .CW(16)) u_dut (
    .clk(clk), .clr_(clr_), .sw_run(sw_run), .step(step), .ir(ir),
    .cf(cf), .zf(zf), .ctl(ctl), .t(t), .halted(halted),
    .instr_done(instr_done), .dbg_state(dbg_state)
  );

  // Wrap instance: MAX_STEP=6 in a 3-bit counter
  logic        w_clr_, w_sw_run, w_step, w_cf, w_zf;
  logic [3:0]  w_ir;
  logic [15:0] w_ctl;
  logic [2:0]  w_t;
  logic        w_halted, w_done;
  logic [1:0]  w_state;

  microcode_sequencer #(.O(4), .T(3), .MAX_STEP(6), .CW(16)) u_wrap (
    .clk(clk), .clr_(w_clr_), .sw_run(w_sw_run), .step(w_step), .ir(w_ir),
    .cf(w_cf), .zf(w_zf), .ctl(w_ctl), .t(w_t), .halted(w_halted),
    .instr_done(w_done), .dbg_state(w_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int et, input logic [15:0] ectl,
                           input logic ed, input logic eh);
    chk({tag, ".t"},      32'(t),          32'(et));
    chk({tag, ".ctl"},    32'(ctl),        32'(ectl));
    chk({tag, ".done"},   32'(instr_done), 32'(ed));
    chk({tag, ".halted"}, 32'(halted),     32'(eh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check outputs at the falling edge of the current cycle, then advance.
  task automatic cyc(input string tag, input int et, input logic [15:0] ectl,
                     input logic ed, input logic eh);
    @(negedge clk);
    check_out(tag, et, ectl, ed, eh);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sw_run;
    logic        step;
    logic [3:0]  ir;
    logic        cf;
    logic        zf;
    logic [2:0]  exp_t;
    logic [15:0] exp_ctl;
    logic        exp_done;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[128];
  int   n_vecs = 0;

  task automatic add_vec(input logic s_run, input logic s_step, input logic [3:0] s_ir,
                         input logic s_cf, input logic s_zf, input int et,
                         input logic [15:0] ectl, input logic ed, input logic eh);
    vecs[n_vecs].sw_run   = s_run;
    vecs[n_vecs].step     = s_step;
    vecs[n_vecs].ir       = s_ir;
    vecs[n_vecs].cf       = s_cf;
    vecs[n_vecs].zf       = s_zf;
    vecs[n_vecs].exp_t    = 3'(et);
    vecs[n_vecs].exp_ctl  = ectl;
    vecs[n_vecs].exp_done = ed;
    vecs[n_vecs].exp_halt = eh;
    n_vecs++;
  endtask

  // One free-running instruction: fetch steps plus hand-written steps 2..4.
  // With early end, the instruction finishes at the first t>=2 whose
  // following step word is zero.
  task automatic add_instr(input logic [3:0] s_ir, input logic s_cf, input logic s_zf,
                           input logic [15:0] c2, input logic [15:0] c3,
                           input logic [15:0] c4);
    logic [15:0] c[6];
    logic        d;
    c[0] = B_CO | B_MI;
    c[1] = B_RO | B_II | B_CE;
    c[2] = c2;
    c[3] = c3;
    c[4] = c4;
    c[5] = 16'h0;
    for (int s = 0; s < 5; s++) begin
      d = (s == 4) || (EARLY && s >= 2 && c[s+1] == 16'h0);
      add_vec(1'b1, 1'b0, s_ir, s_cf, s_zf, s, c[s], d, 1'b0);
      if (d) break;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] fetch[3];
    int          k;
    fetch[0] = B_CO | B_MI;
    fetch[1] = B_RO | B_II | B_CE;
    fetch[2] = B_IO | B_MI;

    clr_ = 1'b0; sw_run = 1'b1; step = 1'b0; ir = I_LDA; cf = 1'b0; zf = 1'b0;
    w_clr_ = 1'b0; w_sw_run = 1'b1; w_step = 1'b0; w_ir = I_NOP; w_cf = 1'b0; w_zf = 1'b0;

    // First vector: WAIT cycle right after reset release
    add_vec(1'b1, 1'b0, I_LDA, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    add_instr(I_LDA, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_AI, 16'h0);
    add_instr(I_ADD, 1'b0, 1'b0, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_FI);
    add_instr(I_SUB, 1'b1, 1'b1, B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_SU | B_FI);
    add_instr(I_STA, 1'b0, 1'b0, B_IO | B_MI, B_AO | B_RI, 16'h0);
    add_instr(I_LDI, 1'b0, 1'b0, B_IO | B_AI, 16'h0, 16'h0);
    add_instr(I_JMP, 1'b0, 1'b0, B_IO | B_J,  16'h0, 16'h0);
    add_instr(I_JC,  1'b0, 1'b1, 16'h0,       16'h0, 16'h0);
    add_instr(I_JC,  1'b1, 1'b0, B_IO | B_J,  16'h0, 16'h0);
    add_instr(I_JZ,  1'b1, 1'b0, 16'h0,       16'h0, 16'h0);
    add_instr(I_JZ,  1'b0, 1'b1, B_IO | B_J,  16'h0, 16'h0);
    add_instr(I_OUT, 1'b0, 1'b0, B_AO | B_OI, 16'h0, 16'h0);
    add_instr(I_NOP, 1'b0, 1'b0, 16'h0,       16'h0, 16'h0);

    // Reset state
    repeat (2) tick();
    #2;
    check_out("reset", 0, 16'h0, 1'b0, 1'b0);
    chk("reset.state", 32'(dbg_state), 32'(S_WAIT));
    tick();

    // Table: release reset, then one vector per cycle
    clr_ = 1'b1;
    for (int i = 0; i < n_vecs; i++) begin
      sw_run = vecs[i].sw_run;
      step   = vecs[i].step;
      ir     = vecs[i].ir;
      cf     = vecs[i].cf;
      zf     = vecs[i].zf;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), int'(vecs[i].exp_t), vecs[i].exp_ctl,
                vecs[i].exp_done, vecs[i].exp_halt);
      tick();
    end

    // HLT: halts on t=2 and stays there; step/sw_run are ignored
    ir = I_HLT; cf = 1'b0; zf = 1'b0;
    cyc("hlt.t0", 0, B_CO | B_MI, 1'b0, 1'b0);
    cyc("hlt.t1", 1, B_RO | B_II | B_CE, 1'b0, 1'b0);
    cyc("hlt.t2", 2, B_HLT, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step   = 1'($urandom_range(0, 1));
      sw_run = 1'($urandom_range(0, 1));
      cyc($sformatf("halted%0d", i), 2, 16'h0, 1'b0, 1'b1);
    end
    chk("halt.state", 32'(dbg_state), 32'(S_HALT));
    clr_ = 1'b0;
    #2;
    check_out("hlt.clr", 0, 16'h0, 1'b0, 1'b0);
    chk("hlt.clr.state", 32'(dbg_state), 32'(S_WAIT));

    // Single-step LDA
    sw_run = 1'b0; step = 1'b0; ir = I_LDA;
    tick();
    clr_ = 1'b1;
    cyc("ss.idle0", 0, 16'h0, 1'b0, 1'b0);
    cyc("ss.idle1", 0, 16'h0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      cyc($sformatf("ss%0d.req", s), s, 16'h0, 1'b0, 1'b0);
      step = 1'b0;
      cyc($sformatf("ss%0d.run", s), s, fetch[s], 1'b0, 1'b0);
      cyc($sformatf("ss%0d.gap", s), s + 1, 16'h0, 1'b0, 1'b0);
    end
    // Held request: exactly one step
    step = 1'b1;
    cyc("hold.req", 3, 16'h0, 1'b0, 1'b0);
    cyc("hold.run", 3, B_RO | B_AI, EARLY, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("hold.wait%0d", i), EARLY ? 0 : 4, 16'h0, 1'b0, 1'b0);
    step = 1'b0;
    cyc("hold.drop", EARLY ? 0 : 4, 16'h0, 1'b0, 1'b0);
    step = 1'b1;
    cyc("ss.last.req", EARLY ? 0 : 4, 16'h0, 1'b0, 1'b0);
    step = 1'b0;
    if (EARLY) begin
      cyc("ss.next.run", 0, B_CO | B_MI, 1'b0, 1'b0);
      cyc("ss.next.gap", 1, 16'h0, 1'b0, 1'b0);
    end else begin
      cyc("ss.last.run", 4, 16'h0, 1'b1, 1'b0);
      cyc("ss.last.gap", 0, 16'h0, 1'b0, 1'b0);
    end

    // Reset in the middle of ADD, then run->step switch
    clr_ = 1'b0; sw_run = 1'b1; ir = I_ADD;
    tick();
    clr_ = 1'b1;
    cyc("add.wait", 0, 16'h0, 1'b0, 1'b0);
    cyc("add.t0", 0, B_CO | B_MI, 1'b0, 1'b0);
    cyc("add.t1", 1, B_RO | B_II | B_CE, 1'b0, 1'b0);
    cyc("add.t2", 2, B_IO | B_MI, 1'b0, 1'b0);
    @(negedge clk);
    check_out("add.t3", 3, B_RO | B_BI, 1'b0, 1'b0);
    #1 clr_ = 1'b0;
    #1;
    check_out("add.clr", 0, 16'h0, 1'b0, 1'b0);
    chk("add.clr.state", 32'(dbg_state), 32'(S_WAIT));
    tick();
    clr_ = 1'b1;
    cyc("add.rst.wait", 0, 16'h0, 1'b0, 1'b0);
    cyc("add.rst.t0", 0, B_CO | B_MI, 1'b0, 1'b0);
    sw_run = 1'b0;
    cyc("sw.t1", 1, B_RO | B_II | B_CE, 1'b0, 1'b0);
    @(negedge clk);
    check_out("sw.wait", 2, 16'h0, 1'b0, 1'b0);
    chk("sw.state", 32'(dbg_state), 32'(S_WAIT));
    tick();
    cyc("sw.wait2", 2, 16'h0, 1'b0, 1'b0);

    // Wrap instance: MAX_STEP=6, random non-halting opcodes
    tick();
    w_clr_ = 1'b1;
    @(negedge clk);
    chk("wrap.wait.t", 32'(w_t), 32'd0);
    chk("wrap.wait.ctl", 32'(w_ctl), 32'd0);
    tick();
    k = 0;
    for (int c = 0; c < 600; c++) begin
      if (w_t == 3'd0) begin
        w_ir = 4'($urandom_range(0, 14));
        w_cf = 1'($urandom_range(0, 1));
        w_zf = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("wrap.range", 32'(w_t < 3'd6), 32'd1);
      if (!EARLY) begin
        chk("wrap.t", 32'(w_t), 32'(k % 6));
        chk("wrap.done", 32'(w_done), 32'((k % 6) == 5));
      end
      if (w_t == 3'd0)
        chk("wrap.fetch", 32'(w_ctl), 32'(B_CO | B_MI));
      tick();
      k++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
